// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD/binary conversion types and constants
//
// Contents:
//   state_t          converter FSM states (IDLE, SHIFT)
//   BCD_DIGIT_W      bits per packed BCD digit
//   BCD_MAX_DIGIT    largest legal BCD digit value
//   DEFAULT_DIGITS   default digit count, shared with the binary-to-BCD path
//   DEFAULT_BIN_W    default binary width, shared with the binary-to-BCD path
//   bcd_digit_valid  true when a 4-bit digit is a legal decimal digit
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_MAX_DIGIT  = 9;
    localparam int DEFAULT_DIGITS = 4;
    localparam int DEFAULT_BIN_W  = 14;

    function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] digit);
        return digit <= BCD_DIGIT_W'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - reverse double-dabble digit correction (subtract 3 if >= 8)
//
// Ports:
//   digit_in   in  BCD_DIGIT_W  one BCD digit after the right shift
//   digit_out  out BCD_DIGIT_W  corrected digit
//
// A digit >= 8 after the right shift means a 1 arrived from the digit above,
// worth 10/2 = 5 here but read as 8; subtracting 3 restores the decimal weight.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= BCD_DIGIT_W'(8)) ? digit_in - BCD_DIGIT_W'(3) : digit_in;

endmodule

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential packed-BCD to binary converter (reverse double-dabble)
//
// Parameters:
//   DIGITS  number of BCD digits in bcd_in
//   BIN_W   width of binary_out and number of shift cycles (10^DIGITS-1 < 2^BIN_W)
//
// Ports:
//   clk         in  1           system clock, rising edge
//   reset       in  1           asynchronous active-high reset
//   start       in  1           conversion request, sampled only while busy=0
//   bcd_in      in  4*DIGITS    packed BCD, digit 0 in [3:0]
//   busy        out 1           conversion in progress
//   done        out 1           one-cycle pulse, binary_out/err valid
//   binary_out  out BIN_W       converted value, held until next done
//   err         out 1           invalid-digit flag, valid with done
//
// Optional feature macro: BCD2BIN_ERR_EN
//   defined   - a start with any digit > 9 completes on the next edge with
//               err=1 and binary_out=0, skipping the shift phase
//   undefined - no digit check, err stays 0
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter int BIN_W  = DEFAULT_BIN_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                          busy,
    output logic                          done,
    output logic [BIN_W-1:0]              binary_out,
    output logic                          err
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIN_W - 1);

    state_t            state_q, state_n;
    logic [SR_W-1:0]   sr_q, sr_n;
    logic [SR_W-1:0]   sr_shift, sr_adj;
    logic [CNT_W-1:0]  count_q, count_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic [BIN_W-1:0]  bin_q, bin_n;
    logic              err_q, err_n;
    logic              reject;

    // sr is {bcd_part, bin_part}; each cycle the whole register moves right
    // one bit and every BCD digit is corrected.
    assign sr_shift = sr_q >> 1;
    assign sr_adj[BIN_W-1:0] = sr_shift[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (sr_shift[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (sr_adj[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef BCD2BIN_ERR_EN
    always_comb begin
        reject = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                reject = 1'b1;
            end
        end
    end
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            sr_q    <= sr_n;
            count_q <= count_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            bin_q   <= bin_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state_q;
        sr_n    = sr_q;
        count_n = count_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        bin_n   = bin_q;
        err_n   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (reject) begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                        bin_n  = '0;
                    end else begin
                        sr_n    = {bcd_in, {BIN_W{1'b0}}};
                        count_n = '0;
                        busy_n  = 1'b1;
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sr_n    = sr_adj;
                count_n = count_q + CNT_W'(1);
                if (count_q == LAST_COUNT) begin
                    bin_n   = sr_adj[BIN_W-1:0];
                    err_n   = 1'b0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign binary_out = bin_q;
    assign err        = err_q;

endmodule
